// File: rtl/dm_arbiter.sv
// Two-port arbiter and two-cycle access sequencer in front of the single-ported data memory.
// Optional macro DM_ARB_RR_EN selects round-robin arbitration; the default build is fixed priority.
module dm_arbiter #(
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [1:0]    size0,
    input  logic [1:0]    size1,
    input  logic [31:0]   addr0,
    input  logic [31:0]   addr1,
    input  logic [31:0]   wdata0,
    input  logic [31:0]   wdata1,
    output logic          done0,
    output logic          done1,
    output logic          err0,
    output logic          err1,
    output logic [31:0]   rdata0,
    output logic [31:0]   rdata1,
    output logic          dm_en,
    output logic [3:0]    dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_wdata,
    input  logic [31:0]   dm_rdata
);

    typedef enum logic {StIdle, StResp} state_e;

    state_e state_q, state_d;
    logic   win_q, win_d;
    logic   we_q, we_d;
    logic   err_q, err_d;
    logic   grant;

    logic        s_we;
    logic [1:0]  s_size;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        misaligned;
    logic [3:0]  be;
    logic [31:0] wd;

    // Address bits above the DM word range carry no meaning here.
    logic unused_addr;
    assign unused_addr = ^{addr0[31:AW+2], addr1[31:AW+2], addr0[1:0] & 2'b00};

`ifdef DM_ARB_RR_EN
    logic last_q, last_d;

    // On contention the port not served last wins.
    assign grant = req1 && (!req0 || !last_q);
`else
    assign grant = req1 && !req0;
`endif

    always_comb begin
        s_we    = grant ? we1    : we0;
        s_size  = grant ? size1  : size0;
        s_addr  = grant ? addr1  : addr0;
        s_wdata = grant ? wdata1 : wdata0;

        misaligned = 1'b0;
        be         = 4'hf;
        wd         = s_wdata;
        unique case (s_size)
            2'b01: begin
                misaligned = s_addr[0];
                be         = s_addr[1] ? 4'hc : 4'h3;
                wd         = {2{s_wdata[15:0]}};
            end
            2'b10: begin
                misaligned = 1'b0;
                be         = 4'b0001 << s_addr[1:0];
                wd         = {4{s_wdata[7:0]}};
            end
            default: begin
                misaligned = (s_addr[1:0] != 2'b00);
                be         = 4'hf;
                wd         = s_wdata;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        we_d     = we_q;
        err_d    = err_q;
`ifdef DM_ARB_RR_EN
        last_d   = last_q;
`endif
        dm_en    = 1'b0;
        dm_we    = 4'h0;
        dm_addr  = '0;
        dm_wdata = 32'h0;
        done0    = 1'b0;
        done1    = 1'b0;
        err0     = 1'b0;
        err1     = 1'b0;
        rdata0   = 32'h0;
        rdata1   = 32'h0;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    state_d = StResp;
                    win_d   = grant;
                    we_d    = s_we;
                    err_d   = misaligned;
`ifdef DM_ARB_RR_EN
                    last_d  = grant;
`endif
                    if (!misaligned) begin
                        dm_en    = 1'b1;
                        dm_we    = s_we ? be : 4'h0;
                        dm_addr  = s_addr[AW+1:2];
                        dm_wdata = s_we ? wd : 32'h0;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
                done0   = !win_q;
                done1   = win_q;
                err0    = !win_q && err_q;
                err1    = win_q && err_q;
                if (!we_q && !err_q) begin
                    rdata0 = win_q ? 32'h0 : dm_rdata;
                    rdata1 = win_q ? dm_rdata : 32'h0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Reset blanks every output and drops any transaction in flight.
        if (!reset) begin
            state_d  = StIdle;
            dm_en    = 1'b0;
            dm_we    = 4'h0;
            dm_addr  = '0;
            dm_wdata = 32'h0;
            done0    = 1'b0;
            done1    = 1'b0;
            err0     = 1'b0;
            err1     = 1'b0;
            rdata0   = 32'h0;
            rdata1   = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef DM_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            we_q    <= we_d;
            err_q   <= err_d;
`ifdef DM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

endmodule
